// File: rtl/accum_core.sv
// accum_core: multi-cycle accumulator processor core with a req/ack memory port.
//   Ports: clk, rst_n (async, active-low); mem_req/mem_we/mem_addr/mem_wdata out,
//   mem_rdata/mem_ack in; pc_out, acc_out, halted status outputs.
//   Define ACCUM_CORE_SAT_EN to make ADD/SUB saturate instead of wrap.
module accum_core #(
  parameter int DATA_W = 8,
  parameter int REG_N = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
  output logic              halted
);
  localparam int RW = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_LDR = 3'b001;
  localparam logic [2:0] OP_STR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_BR  = 3'b111;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, acc_q, acc_d, instr_q, instr_d;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [2:0] op;
  logic [DATA_W-4:0] imm;
  logic [RW-1:0] r;
  logic [DATA_W-1:0] rv, sext, sum, alu, reg_wdata;
  logic is_hlt, sub, reg_we;
  assign op = instr_q[DATA_W-1 -: 3];
  assign imm = instr_q[DATA_W-4:0];
  assign r = imm[RW-1:0];
  assign rv = regs_q[r];
  assign sext = {{3{imm[DATA_W-4]}}, imm};
  assign is_hlt = (op == OP_BR) && (&imm);
  assign sub = (op == OP_SUB);
  assign sum = sub ? acc_q - rv : acc_q + rv;
`ifdef ACCUM_CORE_SAT_EN
  // Overflow when the effective operand signs agree but the result sign differs;
  // clamp towards the sign of the accumulator.
  logic ovf;
  assign ovf = (acc_q[DATA_W-1] ^ rv[DATA_W-1] ^ ~sub) & (sum[DATA_W-1] ^ acc_q[DATA_W-1]);
  assign alu = ovf ? {acc_q[DATA_W-1], {(DATA_W-1){~acc_q[DATA_W-1]}}} : sum;
`else
  assign alu = sum;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = mem_ack ? EXEC : FETCH;
      EXEC: state_d = (op == OP_LW || op == OP_SW) ? MEM : (is_hlt ? HALT : FETCH);
      MEM: state_d = mem_ack ? FETCH : MEM;
      default: state_d = HALT;
    endcase
  end
  // Request lines are gated by rst_n so an asserted reset drops them immediately.
  always_comb begin
    mem_req = rst_n && (state_q == FETCH || state_q == MEM);
    mem_we = rst_n && state_q == MEM && op == OP_SW;
    mem_addr = (state_q == MEM) ? acc_q : pc_q;
    mem_wdata = rv;
  end
  // Single register write port shared by STR (EXEC) and LW (MEM).
  always_comb begin
    pc_d = pc_q;
    acc_d = acc_q;
    instr_d = instr_q;
    reg_we = 1'b0;
    reg_wdata = acc_q;
    regs_d = regs_q;
    if (state_q == FETCH && mem_ack) begin
      instr_d = mem_rdata;
      pc_d = pc_q + DATA_W'(1);
    end
    if (state_q == EXEC) begin
      case (op)
        OP_LDI: acc_d = sext;
        OP_LDR: acc_d = rv;
        OP_STR: reg_we = 1'b1;
        OP_ADD, OP_SUB: acc_d = alu;
        OP_BR: pc_d = (!is_hlt && acc_q != '0) ? rv : pc_q;
        default: ;
      endcase
    end
    if (state_q == MEM && mem_ack && op == OP_LW) begin
      reg_we = 1'b1;
      reg_wdata = mem_rdata;
    end
    if (reg_we) regs_d[r] = reg_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      acc_q <= '0;
      instr_q <= '0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      acc_q <= acc_d;
      instr_q <= instr_d;
      regs_q <= regs_d;
    end
  end
  assign pc_out = pc_q;
  assign acc_out = acc_q;
  assign halted = (state_q == HALT);
endmodule

// File: tb/tb_accum_core.sv
// tb_accum_core: scoreboard bench for accum_core against an ISA-level reference model.
module tb_accum_core;
  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdata;} acc_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_req, mem_we, mem_ack, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out, acc_out;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] prog_q [$];
  acc_t exp_q [$];
  int mem_lat = 0;
  int wait_cnt = 0;
  logic stall = 1'b0;
  logic sb_en = 1'b0;
  logic done = 1'b0;
  logic exp_halt;
  int exp_acc, exp_pc, exp_cyc, n_acc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  accum_core #(.DATA_W(8), .REG_N(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .acc_out(acc_out), .halted(halted)
  );
  assign mem_rdata = mem[mem_addr];
  assign mem_ack = mem_req && !(stall && mem_we) && (wait_cnt >= mem_lat);
  always @(posedge clk) begin
    if (!rst_n) mem <= img;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic int sg(input int x);
    return x > 127 ? x - 256 : x;
  endfunction
  task automatic push(input logic we, input int addr, input int wdata);
    acc_t e;
    e.we = we;
    e.addr = 8'(addr);
    e.wdata = 8'(wdata);
    exp_q.push_back(e);
    n_acc++;
  endtask
  // Instruction-level interpreter: yields the expected access trace and final state.
  task automatic model(input int lat, input int maxi);
    logic [7:0] m [256];
    int rf [8];
    int acc, pc, n, ins, op, imm, r, s;
    m = img;
    foreach (rf[i]) rf[i] = 0;
    acc = 0;
    pc = 0;
    n_acc = 0;
    exp_halt = 1'b0;
    for (n = 0; n < maxi && !exp_halt; n++) begin
      push(1'b0, pc, 0);
      ins = int'(m[pc]);
      pc = (pc + 1) % 256;
      op = ins / 32;
      imm = ins % 32;
      r = imm % 8;
      case (op)
        0: acc = imm >= 16 ? imm + 224 : imm;
        1: acc = rf[r];
        2: rf[r] = acc;
        3, 4: begin
          s = op == 3 ? sg(acc) + sg(rf[r]) : sg(acc) - sg(rf[r]);
`ifdef ACCUM_CORE_SAT_EN
          if (s > 127) s = 127;
          if (s < -128) s = -128;
`endif
          acc = s & 255;
        end
        5: begin push(1'b0, acc, 0); rf[r] = int'(m[acc]); end
        6: begin push(1'b1, acc, rf[r]); m[acc] = 8'(rf[r]); end
        default: if (imm == 31) exp_halt = 1'b1; else if (acc != 0) pc = rf[r];
      endcase
    end
    exp_acc = acc;
    exp_pc = pc;
    exp_cyc = n_acc * (lat + 1) + n;
  endtask
  task automatic load();
    foreach (img[i]) img[i] = 8'h00;
    foreach (prog_q[i]) img[i] = prog_q[i];
  endtask
  task automatic run(input int lat, input int maxi);
    int cyc;
    rst_n = 1'b0;
    mem_lat = lat;
    done = 1'b0;
    exp_q.delete();
    model(lat, maxi);
    repeat (2) @(posedge clk);
    #1;
    sb_en = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    while (!(exp_halt ? halted : done) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d cycles, expected completion", cyc);
    end
    chk("halted", int'(halted), int'(exp_halt));
    chk("queue_left", exp_q.size(), 0);
    if (exp_halt) begin
      chk("halt_cycle", cyc, exp_cyc);
      chk("acc", int'(acc_out), exp_acc);
      chk("pc", int'(pc_out), exp_pc);
    end
    sb_en = 1'b0;
  endtask
  // Monitor: hold checks, per-access cycle count, scoreboard pop on every ack.
  initial begin
    acc_t e;
    logic pend;
    logic [16:0] prev;
    int acyc;
    pend = 1'b0;
    prev = '0;
    acyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        acyc++;
        if (pend) chk("req_hold", int'({mem_we, mem_addr, mem_wdata}), int'(prev));
        if (mem_ack) begin
          chk("access_cycles", acyc, mem_lat + 1);
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_access: got addr 0x%0h, expected none", mem_addr);
            end else begin
              e = exp_q.pop_front();
              chk("acc_we", int'(mem_we), int'(e.we));
              chk("acc_addr", int'(mem_addr), int'(e.addr));
              if (e.we) chk("acc_wdata", int'(mem_wdata), int'(e.wdata));
              if (exp_q.size() == 0) done = 1'b1;
            end
          end
          pend = 1'b0;
          acyc = 0;
        end else begin
          pend = 1'b1;
          prev = {mem_we, mem_addr, mem_wdata};
        end
      end else begin
        pend = 1'b0;
        acyc = 0;
      end
    end
  end
  initial begin
    int cyc;
    int op, imm;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", int'(mem_req), 0);
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_halted", int'(halted), 0);
    prog_q = '{8'h05, 8'h41, 8'h61, 8'hFF};
    load();
    run(0, 100);
    chk("basic_acc", int'(acc_out), 8'h0A);
    chk("basic_pc", int'(pc_out), 8'h04);
    run(3, 100);
    chk("wait_acc", int'(acc_out), 8'h0A);
    prog_q = '{8'h10, 8'hA2, 8'h01, 8'h43, 8'h22, 8'h63, 8'hFF};
    load();
    img[8'hF0] = 8'h7F;
    run(0, 100);
`ifdef ACCUM_CORE_SAT_EN
    chk("loadadd_acc", int'(acc_out), 8'h7F);
`else
    chk("loadadd_acc", int'(acc_out), 8'h80);
`endif
    prog_q = '{8'h08, 8'h41, 8'h61, 8'h41, 8'h61, 8'h41, 8'h00, 8'hE1, 8'h01, 8'hE1, 8'hFF};
    load();
    img[8'h20] = 8'hFF;
    run(0, 100);
    chk("branch_pc", int'(pc_out), 8'h21);
    prog_q = '{8'h10, 8'hA1, 8'h11, 8'hA2, 8'h22, 8'hC1, 8'hFF};
    load();
    img[8'hF0] = 8'h5A;
    img[8'hF1] = 8'h30;
    run(1, 100);
    chk("store_mem", int'(mem[8'h30]), 8'h5A);
    prog_q = '{8'h05, 8'h41, 8'h10, 8'hC1};
    load();
    rst_n = 1'b0;
    mem_lat = 0;
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_we", int'(mem_we), 1);
    chk("stall_addr", int'(mem_addr), 8'hF0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(mem_req), 0);
    chk("mid_rst_pc", int'(pc_out), 0);
    chk("mid_rst_acc", int'(acc_out), 0);
    stall = 1'b0;
    prog_q = '{8'h21, 8'hFF};
    load();
    run(0, 100);
    chk("post_rst_r1", int'(acc_out), 0);
    for (int t = 0; t < 20; t++) begin
      foreach (img[i]) img[i] = 8'($urandom);
      for (int i = 0; i < 20; i++) begin
        op = $urandom_range(0, 7);
        imm = $urandom_range(0, 31);
        if (op == 7 && imm == 31) imm = 30;
        img[i] = 8'(op * 32 + imm);
      end
      img[20] = 8'hFF;
      run($urandom_range(0, 2), 60);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
